// File: rtl/router_pkg.sv
// Shared router definitions for the packet-connected-circuit router.
//   - Port index constants (0=L, 1=N, 2=E, 3=S, 4=W)
//   - Port count, address width, crossbar select width
//   - Output-port state enum
//   - xy_route: dimension-ordered (X first, then Y) route computation
package router_pkg;
  localparam int NPORT  = 5;
  localparam int ADDRYX = 8;
  localparam int SELW   = 3;

  localparam logic [2:0] P_L = 3'd0;
  localparam logic [2:0] P_N = 3'd1;
  localparam logic [2:0] P_E = 3'd2;
  localparam logic [2:0] P_S = 3'd3;
  localparam logic [2:0] P_W = 3'd4;

  typedef enum logic {FREE = 1'b0, BUSY = 1'b1} ostate_e;

  // addr[7:4] = dest Y, addr[3:0] = dest X; unsigned compares.
  function automatic logic [2:0] xy_route(input logic [ADDRYX-1:0] addr,
                                          input logic [3:0] lx,
                                          input logic [3:0] ly);
    if (addr[3:0] > lx)      return P_E;
    else if (addr[3:0] < lx) return P_W;
    else if (addr[7:4] > ly) return P_N;
    else if (addr[7:4] < ly) return P_S;
    else                     return P_L;
  endfunction
endpackage

// File: rtl/xy_port_allocator_rr_arb5.sv
// rr_arb5: pure combinational 5-way round-robin arbiter.
//   i_req : request vector
//   i_ptr : last winner; search starts at i_ptr+1 mod 5
//   o_gnt : one-hot winner (0 if no request)
//   o_idx : winner index
//   o_any : at least one request present
module rr_arb5 (
  input  logic [4:0] i_req,
  input  logic [2:0] i_ptr,
  output logic [4:0] o_gnt,
  output logic [2:0] o_idx,
  output logic       o_any
);
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    // Walk from farthest to nearest so the nearest requester after i_ptr
    // is the last (winning) assignment.
    for (int k = 5; k >= 1; k--) begin
      int c;
      c = (int'(i_ptr) + k) % 5;
      if (i_req[c]) begin
        o_gnt = 5'b00001 << c;
        o_idx = 3'(c);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/xy_port_allocator.sv
// xy_port_allocator: per-router output-port allocator.
// Routes each input's destination XY-first, round-robin arbitrates each
// output, pulses grant/deny back to the input FSMs for one cycle and drives
// the crossbar select/valid lines. A granted circuit is held until the owner
// drops its strobe or the crossbar cancels it.
// Optional macro ARB_WATCHDOG_EN: per-output watchdog releases a circuit
// (with a deny pulse to the owner) if no pack_i is seen within TIMEOUT cycles.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   request_i    : per-input request level
//   address_i    : per-input destination, slice i = [i*ADDRYX +: ADDRYX]
//   stb_i        : per-input link strobe
//   cancel_i     : per-input cancel from the crossbar
//   pack_i       : per-input pack acknowledge (watchdog only)
//   grant_o      : one-cycle grant pulse per input
//   deny_o       : one-cycle deny pulse per input
//   xbar_sel_o   : per-output owning input index (holds while invalid)
//   xbar_vld_o   : per-output circuit established
module xy_port_allocator
  import router_pkg::*;
#(
  parameter logic [3:0] LOCAL_Y = 4'b0010,
  parameter logic [3:0] LOCAL_X = 4'b0010,
  parameter int         TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORT-1:0]        request_i,
  input  logic [NPORT*ADDRYX-1:0] address_i,
  input  logic [NPORT-1:0]        stb_i,
  input  logic [NPORT-1:0]        cancel_i,
  input  logic [NPORT-1:0]        pack_i,
  output logic [NPORT-1:0]        grant_o,
  output logic [NPORT-1:0]        deny_o,
  output logic [NPORT*SELW-1:0]   xbar_sel_o,
  output logic [NPORT-1:0]        xbar_vld_o
);
  ostate_e                     r_state [NPORT];
  logic [NPORT-1:0][SELW-1:0]  r_sel;   // doubles as owner index while BUSY
  logic [NPORT-1:0][2:0]       r_ptr;
  logic [NPORT-1:0]            r_grant, r_deny;

  logic [NPORT-1:0][2:0]       w_route;
  logic [NPORT-1:0]            w_is_owner, w_elig, w_rel, w_tmo, w_any;
  logic [NPORT-1:0][NPORT-1:0] w_oreq, w_gnt;
  logic [NPORT-1:0][2:0]       w_idx;
  logic [NPORT-1:0]            w_grant_n, w_deny_n;

  always_comb begin
    w_is_owner = '0;
    for (int o = 0; o < NPORT; o++)
      if (r_state[o] == BUSY) w_is_owner[r_sel[o]] = 1'b1;
  end

  // Owners are excluded: their request level lingers a cycle past grant.
  always_comb begin
    w_route = '0;
    w_oreq  = '0;
    for (int i = 0; i < NPORT; i++)
      w_route[i] = xy_route(address_i[i*ADDRYX +: ADDRYX], LOCAL_X, LOCAL_Y);
    w_elig = request_i & stb_i & ~w_is_owner;
    for (int o = 0; o < NPORT; o++)
      for (int i = 0; i < NPORT; i++)
        w_oreq[o][i] = w_elig[i] && (w_route[i] == 3'(o));
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    rr_arb5 u_arb (
      .i_req (w_oreq[o]),
      .i_ptr (r_ptr[o]),
      .o_gnt (w_gnt[o]),
      .o_idx (w_idx[o]),
      .o_any (w_any[o])
    );
    assign w_rel[o] = (r_state[o] == BUSY) &&
                      (!stb_i[r_sel[o]] || cancel_i[r_sel[o]] || w_tmo[o]);
    assign xbar_vld_o[o] = (r_state[o] == BUSY);
  end

  always_comb begin
    w_grant_n = '0;
    w_deny_n  = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (r_state[o] == BUSY) begin
        // Still BUSY in a release cycle: requesters retry next cycle.
        w_deny_n = w_deny_n | w_oreq[o];
        if (w_tmo[o]) w_deny_n[r_sel[o]] = 1'b1;
      end else if (w_any[o]) begin
        w_grant_n = w_grant_n | w_gnt[o];
        w_deny_n  = w_deny_n | (w_oreq[o] & ~w_gnt[o]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= '0;
      r_deny  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      for (int o = 0; o < NPORT; o++) r_state[o] <= FREE;
    end else begin
      r_grant <= w_grant_n;
      r_deny  <= w_deny_n;
      for (int o = 0; o < NPORT; o++) begin
        if (r_state[o] == BUSY) begin
          if (w_rel[o]) r_state[o] <= FREE;
        end else if (w_any[o]) begin
          r_state[o] <= BUSY;
          r_sel[o]   <= w_idx[o];
          r_ptr[o]   <= w_idx[o];
        end
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [NPORT-1:0][CW-1:0] r_cnt;
  logic [NPORT-1:0]         r_run;

  for (genvar o = 0; o < NPORT; o++) begin : g_wd
    assign w_tmo[o] = (r_state[o] == BUSY) && r_run[o] && !pack_i[r_sel[o]] &&
                      (r_cnt[o] == CW'(TIMEOUT - 1));
  end

  // Counter starts at grant, freezes at the owner's first pack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_run <= '0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (r_state[o] == FREE && w_any[o]) begin
          r_cnt[o] <= '0;
          r_run[o] <= 1'b1;
        end else if (r_state[o] == BUSY && r_run[o]) begin
          if (pack_i[r_sel[o]]) r_run[o] <= 1'b0;
          else if (w_tmo[o]) begin
            r_cnt[o] <= '0;
            r_run[o] <= 1'b0;
          end else r_cnt[o] <= r_cnt[o] + 1'b1;
        end
      end
    end
  end
`else
  logic w_unused_wd;
  assign w_tmo       = '0;
  assign w_unused_wd = ^pack_i ^ (TIMEOUT > 0);
`endif

  assign grant_o    = r_grant;
  assign deny_o     = r_deny;
  assign xbar_sel_o = r_sel;
endmodule

// File: doc/xy_port_allocator.md
Name: xy_port_allocator

Overview:
- Per-router output-port allocator for the packet-connected-circuit router.
- Takes the request and 8-bit destination address from each of the five input-port FSMs, computes the XY route, and round-robin arbitrates each output port.
- Drives one-cycle grant/deny pulses back to the input FSMs, and drives crossbar select lines.
- Holds each granted circuit until the owning input drops its strobe or the crossbar cancels it.

Parameters:
- LOCAL_Y, 4'b0010, router Y coordinate.
- LOCAL_X, 4'b0010, router X coordinate.
- NPORT, 5, number of ports (fixed encoding: 0=L, 1=N, 2=E, 3=S, 4=W).
- ADDRYX, 8, address width; [7:4]=dest Y, [3:0]=dest X.
- SELW, 3, crossbar select width per output.
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- request_i  in  NPORT  per-input request level from the input FSM (registered there)
- address_i  in  NPORT*ADDRYX  per-input destination; slice i = [i*ADDRYX +: ADDRYX]
- stb_i  in  NPORT  per-input link strobe
- cancel_i  in  NPORT  per-input cancel, relayed from the crossbar
- pack_i  in  NPORT  per-input pack acknowledge
- grant_o  out  NPORT  one-cycle grant pulse per input
- deny_o  out  NPORT  one-cycle deny pulse per input
- xbar_sel_o  out  NPORT*SELW  per-output index of the owning input
- xbar_vld_o  out  NPORT  per-output "circuit established"

Behaviour:
- Reset: all outputs 0; all outputs FREE; all inputs IDLE; RR pointers = 0.
- Route (combinational), per input:
  - dX > LOCAL_X -> E; dX < LOCAL_X -> W.
  - Otherwise dY > LOCAL_Y -> N; dY < LOCAL_Y -> S.
  - Otherwise -> L.
  - Comparisons are unsigned 4-bit.
- Eligible request: request_i[i] && stb_i[i] && input i is not an owner.
  - Owner inputs are ignored: their stale request persists one cycle after grant.
- Per output o, state FREE/BUSY:
  - FREE with ≥1 eligible requester: pick a winner by round-robin, starting at ptr[o]+1 mod NPORT.
    - Winner: grant_o=1 for one cycle; o goes BUSY; owner[o]=winner; ptr[o]=winner.
    - All other eligible requesters to o: deny_o=1 the same cycle.
  - BUSY with an eligible requester: deny_o=1 for that requester.
  - BUSY -> FREE when the owner's stb_i=0 or cancel_i=1 is sampled.
    - xbar_vld_o drops the cycle after.
    - A new request to o can be granted in the cycle following the release, not in the same cycle.
- Latency:
  - Registered grant/deny: request sampled at edge k, pulse valid during cycle k..k+1.
  - xbar_sel_o/xbar_vld_o update at the same edge as grant.
- Grant and deny are never both set for the same input in one cycle.
- An input owns at most one output.
- Simultaneous release of o and a new request to o: release wins; the request is re-arbitrated next cycle.
- stb_i dropping on a requester before arbitration: no grant, no deny.
- xbar_sel_o holds its last value while invalid.

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- Defined: per-output counter (clog2(TIMEOUT)+1 bits) starts at grant and stops at first pack_i of the owner.
  - On reaching TIMEOUT without pack: deny_o pulse to the owner, output released, counter cleared.
- Undefined: no counter logic; pack_i is unused; a circuit is held until strobe drop or cancel.

Decomposition:
- Package router_pkg:
  - Port index constants P_L/P_N/P_E/P_S/P_W.
  - NPORT, ADDRYX, SELW.
  - Output state enum FREE/BUSY.
  - xy_route function.
- Sub-module rr_arb5: pure round-robin arbiter (req[4:0], ptr[2:0] -> onehot gnt, idx).
  - One instance per output port.

Test Plan:
1. Local (2,2); input W requests addr 8'h25 -> next cycle grant_o[4]=1; xbar_sel E(2)=4; xbar_vld[2]=1; deny_o=0.
2. Inputs N and S both request 8'h22 (Local) in the same cycle, ptr[L]=0 -> N granted, S denied in the same cycle; then N drops stb -> vld[L]=0 one cycle later.
3. E owns output W; L requests 8'h20 -> deny_o[0] pulse; E asserts cancel_i -> W freed; L re-requests -> granted.
4. Round-robin fairness: inputs 1..4 continuously re-request dest 8'h22, each released after 3 cycles -> grants rotate 1,2,3,4,1.
5. Stale request: granted input keeps request_i=1 for one extra cycle -> no second grant, no deny.
6. ARB_WATCHDOG_EN, TIMEOUT=64: grant with no pack -> deny pulse at cycle 64 after grant, output freed; with pack at cycle 10 -> no timeout.
